vt_deletion_decoder: RTL and testbench
======================================

VT_DELETION_DECODER -- requirements
Module: vt_deletion_decoder

Interface
REQ-001 SHALL have parameter N, default 10, meaning codeword length in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning received-word buffer width (DATA_WIDTH >= N).
REQ-003 SHALL have parameter A, default 0, meaning VT residue a, where sum of (k+1)*x[k] over k=0..N-1 equals a mod (N+1).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all flops on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1, meaning received word offered.
REQ-007 SHALL have port in_ready, output, 1, meaning decoder can accept a word.
REQ-008 SHALL have port data_in, input, DATA_WIDTH, meaning received word; bit k is symbol position k+1.
REQ-009 SHALL have port n_in, input, 32 (int), meaning received length (channel n_out).
REQ-010 SHALL have port out_valid, output, 1, meaning result held.
REQ-011 SHALL have port out_ready, input, 1, meaning consumer accepts result.
REQ-012 SHALL have port data_out, output, N, meaning decoded codeword.
REQ-013 SHALL have port status, output, 2, meaning 00 clean, 01 corrected, 10 uncorrectable.

Function
REQ-014 SHALL use FSM states IDLE, SUM, LOCATE and DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE; on in_valid&&in_ready, latch data_in and n_in.
- If n_in is N-1 or N, go to SUM.
- Otherwise go to DONE with status=10 and data_out=0.
REQ-016 SUM SHALL process one bit per cycle, k=0..n_in-1, for n_in cycles.
- Weight w += y[k].
- Checksum s = (s + (k+1)*y[k]) mod (N+1), reduced every cycle and held in ceil(log2(N+1)) bits.
REQ-017 After SUM with n_in==N: go to DONE; s==A gives status 00, data_out=y[N-1:0]; otherwise status 10, data_out=y[N-1:0].
REQ-018 After SUM with n_in==N-1: compute D=(A-s) mod (N+1).
- If D<=w, the deleted bit is 0.
- Otherwise the deleted bit is 1, with target T=D-w-1.
- Go to LOCATE.
REQ-019 LOCATE SHALL scan p=0,1,... one index per cycle and stop at the first p satisfying the rule for the deleted bit.
- Deleted bit 0: rem starts at w; stop when rem==D, else rem-=y[p].
- Deleted bit 1: zeros starts at 0; stop when zeros==T, else zeros+=!y[p].
- p SHALL saturate at N-1.
REQ-020 On stop, SHALL register the output and enter DONE next cycle.
- data_out[k]=y[k] for k<p; data_out[p]=deleted bit; data_out[k]=y[k-1] for k>p.
- status=01.
REQ-021 DONE SHALL assert out_valid and hold data_out and status stable until out_ready; on out_valid&&out_ready, return to IDLE.
REQ-022 Latency from accept SHALL be n_in (SUM) + p+1 (LOCATE, deletion case only) + 1 cycles to out_valid.
REQ-023 Data_in bits at index >= n_in SHALL be ignored.

Reset
REQ-024 On rst_n low, asynchronously: state=IDLE, in_ready=0 during reset and 1 after release, out_valid=0, data_out=0, status=00, all counters 0.
REQ-025 Reset asserted mid-SUM, mid-LOCATE or in DONE SHALL discard the word; no out_valid for it after release.

Configuration
REQ-026 With VT_DEC_STATS_EN defined, SHALL add outputs cnt_corr[15:0] and cnt_fail[15:0].
- They count handshaked results with status 01 and 10 respectively.
- They saturate at 16'hFFFF and reset to 0.
REQ-027 Without VT_DEC_STATS_EN, those ports and counters SHALL be absent, with no other behaviour change.

Verification (N=10, A=0)
REQ-028 n_in=9, data_in=0 -> D=0, deleted bit 0, p=0; data_out=10'b0, status=01, out_valid at cycle 9+1+1=11 after accept.
REQ-029 n_in=9, data_in=9'b100000000 (codeword 10'b1000000001 with bit 0 deleted) -> s=9, w=1, D=2, deleted bit 1, T=0, p=0; data_out=10'b1000000001, status=01.
REQ-030 n_in=9, data_in=9'b100000001 (index 4 deleted) -> s=10, w=2, D=1, deleted bit 0, p=1; data_out=10'b1000000001, status=01.
REQ-031 n_in=10, data_in=10'b1000000001 -> status=00; n_in=10, data_in=10'b0000000001 -> status=10; n_in=7 -> status=10, data_out=0 one cycle after accept.
REQ-032 Hold out_ready=0 for 5 cycles in DONE -> out_valid and data_out stable, in_ready=0; pulse rst_n low mid-LOCATE -> out_valid=0, FSM back in IDLE.

Source files
------------

// File: rtl/vt_deletion_decoder_if.sv
// Handshake bundle for the VT deletion decoder: word in, result out.
// master = producer/consumer side, slave = decoder side.
interface vt_deletion_decoder_if #(
  parameter int N          = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] data_in;
  int                    n_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [N-1:0]          data_out;
  logic [1:0]            status;

  modport master (
    output in_valid, data_in, n_in, out_ready,
    input  in_ready, out_valid, data_out, status
  );

  modport slave (
    input  in_valid, data_in, n_in, out_ready,
    output in_ready, out_valid, data_out, status
  );
endinterface

// File: rtl/vt_deletion_decoder.sv
// Varshamov-Tenengolts single-deletion decoder (IDLE/SUM/LOCATE/DONE).
// Ports: clk, rst_n (async low), bus (slave); VT_DEC_STATS_EN adds cnt_corr/cnt_fail.
module vt_deletion_decoder #(
  parameter int N          = 10,
  parameter int DATA_WIDTH = 32,
  parameter int A          = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vt_deletion_decoder_if.slave  bus
`ifdef VT_DEC_STATS_EN
  ,
  output logic [15:0]           cnt_corr,
  output logic [15:0]           cnt_fail
`endif
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] AM = CW'(A % (N + 1));
  localparam logic [CW-1:0] NN = CW'(N);
  localparam logic [CW-1:0] NL = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, SUM, LOCATE, DONE} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    y_q, y_d;
  logic [CW-1:0]   n_q, n_d;
  logic [CW-1:0]   k_q, k_d;
  logic [CW-1:0]   s_q, s_d;
  logic [CW-1:0]   w_q, w_d;
  logic [CW-1:0]   ones_q, ones_d;
  logic [N-1:0]    data_q, data_d;
  logic [1:0]      status_q, status_d;

  logic            accept;
  logic            release_out;
  logic            len_ok;
  logic            sum_last;
  logic            stop;
  logic            del_bit;
  logic [CW-1:0]   s_nxt;
  logic [CW-1:0]   dd;
  logic [CW-1:0]   tt;
  logic [CW-1:0]   rem;
  logic [CW-1:0]   zeros;
  logic [N-1:0]    shifted;
  logic [N-1:0]    ins;

  assign accept      = bus.in_valid && bus.in_ready;
  assign release_out = bus.out_valid && bus.out_ready;
  assign len_ok      = (bus.n_in == N) || (bus.n_in == N - 1);
  assign sum_last    = (k_q == n_q - CW'(1));

  // Checksum step, reduced every cycle so it never exceeds N.
  always_comb begin
    int t;
    t = int'(s_q);
    if (y_q[k_q]) t = t + int'(k_q) + 1;
    if (t > N) t = t - (N + 1);
    s_nxt = CW'(t);
  end

  // Deficiency D = (A - s) mod (N+1) on the final checksum.
  always_comb begin
    int d;
    d = (int'(AM) >= int'(s_q)) ? int'(AM) - int'(s_q)
                                : int'(AM) + N + 1 - int'(s_q);
    dd = CW'(d);
  end

  // rem = w - ones seen so far; zeros = p - ones seen so far.
  assign del_bit = (dd > w_q);
  assign tt      = dd - w_q - CW'(1);
  assign rem     = w_q - ones_q;
  assign zeros   = k_q - ones_q;
  assign stop    = (k_q == NL) ||
                   (del_bit ? (zeros == tt) : (rem == dd));

  assign shifted = {y_q[N-2:0], 1'b0};

  always_comb begin
    ins = '0;
    for (int i = 0; i < N; i++) begin
      if (i < int'(k_q))       ins[i] = y_q[i];
      else if (i == int'(k_q)) ins[i] = del_bit;
      else                     ins[i] = shifted[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)      state_d = len_ok ? SUM : DONE;
      SUM:     if (sum_last)    state_d = (n_q == NN) ? DONE : LOCATE;
      LOCATE:  if (stop)        state_d = DONE;
      DONE:    if (release_out) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE) && rst_n;
    bus.out_valid = (state_q == DONE);
    bus.data_out  = data_q;
    bus.status    = status_q;
  end

  always_comb begin
    y_d      = y_q;
    n_d      = n_q;
    k_d      = k_q;
    s_d      = s_q;
    w_d      = w_q;
    ones_d   = ones_q;
    data_d   = data_q;
    status_d = status_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          y_d    = bus.data_in[N-1:0];
          n_d    = len_ok ? CW'(bus.n_in) : '0;
          k_d    = '0;
          s_d    = '0;
          w_d    = '0;
          ones_d = '0;
          if (!len_ok) begin
            data_d   = '0;
            status_d = 2'b10;
          end
        end
      end
      SUM: begin
        s_d = s_nxt;
        w_d = w_q + CW'(y_q[k_q]);
        k_d = k_q + CW'(1);
        if (sum_last) begin
          k_d = '0;
          if (n_q == NN) begin
            data_d   = y_q;
            status_d = (s_nxt == AM) ? 2'b00 : 2'b10;
          end
        end
      end
      LOCATE: begin
        if (stop) begin
          data_d   = ins;
          status_d = 2'b01;
        end else begin
          k_d    = k_q + CW'(1);
          ones_d = ones_q + CW'(y_q[k_q]);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q      <= '0;
      n_q      <= '0;
      k_q      <= '0;
      s_q      <= '0;
      w_q      <= '0;
      ones_q   <= '0;
      data_q   <= '0;
      status_q <= '0;
    end else begin
      y_q      <= y_d;
      n_q      <= n_d;
      k_q      <= k_d;
      s_q      <= s_d;
      w_q      <= w_d;
      ones_q   <= ones_d;
      data_q   <= data_d;
      status_q <= status_d;
    end
  end

`ifdef VT_DEC_STATS_EN
  logic [15:0] cnt_corr_q, cnt_corr_d;
  logic [15:0] cnt_fail_q, cnt_fail_d;

  always_comb begin
    cnt_corr_d = cnt_corr_q;
    cnt_fail_d = cnt_fail_q;
    if (release_out) begin
      if (status_q == 2'b01 && cnt_corr_q != 16'hFFFF)
        cnt_corr_d = cnt_corr_q + 16'd1;
      if (status_q == 2'b10 && cnt_fail_q != 16'hFFFF)
        cnt_fail_d = cnt_fail_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_corr_q <= '0;
      cnt_fail_q <= '0;
    end else begin
      cnt_corr_q <= cnt_corr_d;
      cnt_fail_q <= cnt_fail_d;
    end
  end

  assign cnt_corr = cnt_corr_q;
  assign cnt_fail = cnt_fail_q;
`endif

endmodule

// File: tb/tb_vt_deletion_decoder.sv
// Directed bench for vt_deletion_decoder (N=10, A=0) with a result queue.
// Expected words/status are pushed on accept and compared on out handshake.
module tb_vt_deletion_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vt_deletion_decoder_if #(.N(10), .DATA_WIDTH(32)) bus ();

`ifdef VT_DEC_STATS_EN
  logic [15:0] cnt_corr;
  logic [15:0] cnt_fail;
`endif

  vt_deletion_decoder #(.N(10), .DATA_WIDTH(32), .A(0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus)
`ifdef VT_DEC_STATS_EN
    ,
    .cnt_corr (cnt_corr),
    .cnt_fail (cnt_fail)
`endif
  );

  typedef struct {
    logic [9:0] data;
    logic [1:0] st;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [31:0] din, input int n,
                     input logic [9:0] ed, input logic [1:0] es,
                     input int lat, input int hold);
    exp_t e;
    exp_t got;
    int   cyc;
    @(negedge clk);
    chk("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.data_in  = din;
    bus.n_in     = n;
    e.data = ed;
    e.st   = es;
    q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.data_in  = '0;
    for (cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    chk("latency", cyc, lat);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_data", bus.data_out, q[0].data);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    got = q.pop_front();
    chk("data_out", bus.data_out, got.data);
    chk("status", bus.status, got.st);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("out_valid_clr", bus.out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   hits;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.n_in      = 0;
    bus.out_ready = 1'b0;

    #12;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_status", bus.status, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", bus.in_ready, 1);

    run(32'h0000_0000, 9,  10'b0000000000, 2'b01, 11, 0);
    run(32'h0000_0100, 9,  10'b1000000001, 2'b01, 11, 0);
    run(32'h0000_0101, 9,  10'b1000000001, 2'b01, 12, 0);
    run(32'h0000_0201, 10, 10'b1000000001, 2'b00, 11, 0);
    run(32'h0000_0001, 10, 10'b0000000001, 2'b10, 11, 0);
    run(32'h0000_0055, 7,  10'b0000000000, 2'b10, 1,  0);
    run(32'h0000_0000, 11, 10'b0000000000, 2'b10, 1,  0);
    run(32'hFFFF_FE00, 9,  10'b0000000000, 2'b01, 11, 0);
    run(32'h0000_001F, 9,  10'b0001011111, 2'b01, 17, 5);
    run(32'h0000_0001, 9,  10'b1000000001, 2'b01, 20, 0);

`ifdef VT_DEC_STATS_EN
    chk("cnt_corr", cnt_corr, 6);
    chk("cnt_fail", cnt_fail, 3);
`endif

    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.data_in  = 32'h0000_001F;
    bus.n_in     = 9;
    e.data = 10'b0001011111;
    e.st   = 2'b01;
    q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    chk("midrst_data", bus.data_out, 0);
    chk("midrst_status", bus.status, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_idle", bus.in_ready, 1);
    hits = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.out_valid) hits++;
    end
    chk("midrst_no_result", hits, 0);
    chk("midrst_queue", q.size(), 0);

`ifdef VT_DEC_STATS_EN
    chk("cnt_corr_rst", cnt_corr, 0);
`endif

    run(32'h0000_0101, 9, 10'b1000000001, 2'b01, 12, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
